// File: rtl/twiddle_gen.sv
// rtl/twiddle_gen.sv - Twiddle-factor source emitting pre-added (c, c+s, s-c) per radix-2 DIF butterfly
// The twiddle table uses the TWIDDLE_FILE layout: N/2 words of {cos, sin} in Q1.15
// for W_k = exp(-j*2*pi*k/N), with +1.0 saturated to 0x7FFF. The words are
// generated at elaboration, so the ROM contents always match LOG2N.
module twiddle_gen #(
  parameter int LOG2N        = 10,
  parameter     TWIDDLE_FILE = "twiddle_rom.hex"
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [$clog2(LOG2N)-1:0] stage,
  input  logic                     stall,
  output logic                     busy,
  output logic                     twiddle_valid,
  output logic                     twiddle_last,
  output logic [15:0]              twiddle_real,
  output logic [16:0]              twiddle_sum,
  output logic [16:0]              twiddle_diff
);

  localparam int HALF = 1 << (LOG2N - 1);
  localparam int KW   = LOG2N - 1;
  localparam int SW   = $clog2(LOG2N);

  // Q28 fixed-point constants for table generation
  localparam longint ONE_Q28 = 64'sd268435456;
  localparam longint PI_Q28  = 64'sd843314857;

  // Round a Q28 value to Q15, saturating +1.0 to the largest positive code
  function automatic longint q15(input longint v);
    longint r;
    r = (v + 64'sd4096) >>> 13;
    if (r > 64'sd32767) r = 64'sd32767;
    return r;
  endfunction

  // Table word for index k: angle folded into [0, pi/2], then Taylor series
  function automatic logic [31:0] rom_word(input int k);
    longint x;
    longint term;
    longint cs;
    longint sn;
    longint re;
    longint im;
    int     kk;
    logic   neg;
    kk  = k;
    neg = 1'b0;
    if (2 * k > HALF) begin
      kk  = HALF - k;
      neg = 1'b1;
    end
    x    = (64'sd2 * PI_Q28 * longint'(kk)) >>> LOG2N;
    term = ONE_Q28;
    cs   = ONE_Q28;
    sn   = 64'sd0;
    for (int n = 1; n <= 24; n++) begin
      term = (term * x) / (ONE_Q28 * longint'(n));
      case (n % 4)
        1:       sn = sn + term;
        2:       cs = cs - term;
        3:       sn = sn - term;
        default: cs = cs + term;
      endcase
    end
    re = q15(neg ? -cs : cs);
    im = q15(-sn);
    return {re[15:0], im[15:0]};
  endfunction

  logic [31:0] rom [HALF];

  for (genvar i = 0; i < HALF; i++) begin : g_rom
    localparam logic [31:0] WORD = rom_word(i);
    assign rom[i] = WORD;
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state;
  logic [KW-1:0] j;
  logic [SW-1:0] stage_q;
  logic [KW-1:0] idx_mask;
  logic [KW-1:0] idx_k;

  logic          p0_valid;
  logic          p0_last;
  logic [KW-1:0] p0_k;
  logic          p1_valid;
  logic          p1_last;
  logic [15:0]   p1_c;
  logic [15:0]   p1_s;

  // Twiddle index for butterfly j: position within its group, scaled by the stage stride
  always_comb begin
    idx_mask = KW'((HALF >> stage_q) - 1);
    idx_k    = KW'((j & idx_mask) << stage_q);
  end

  // Sequencer: accept a stage, issue N/2 indices into P0, then wait for the last output to leave
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      j        <= '0;
      stage_q  <= '0;
      busy     <= 1'b0;
      p0_valid <= 1'b0;
      p0_last  <= 1'b0;
      p0_k     <= '0;
    end else if (!stall) begin
      p0_valid <= 1'b0;
      p0_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            stage_q <= stage;
            j       <= '0;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          p0_valid <= 1'b1;
          p0_k     <= idx_k;
          p0_last  <= (j == KW'(HALF - 1));
          j        <= j + 1'b1;
          if (j == KW'(HALF - 1)) state <= DRAIN;
        end
        DRAIN: begin
          if (twiddle_valid && twiddle_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // P1 ROM read and P2 pre-add output register; data outputs only change on valid beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid      <= 1'b0;
      p1_last       <= 1'b0;
      p1_c          <= '0;
      p1_s          <= '0;
      twiddle_valid <= 1'b0;
      twiddle_last  <= 1'b0;
      twiddle_real  <= '0;
      twiddle_sum   <= '0;
      twiddle_diff  <= '0;
    end else if (!stall) begin
      p1_valid      <= p0_valid;
      p1_last       <= p0_last;
      {p1_c, p1_s}  <= rom[p0_k];
      twiddle_valid <= p1_valid;
      twiddle_last  <= p1_valid & p1_last;
      if (p1_valid) begin
        twiddle_real <= p1_c;
        twiddle_sum  <= {p1_c[15], p1_c} + {p1_s[15], p1_s};
        twiddle_diff <= {p1_s[15], p1_s} - {p1_c[15], p1_c};
      end
    end
  end

endmodule

// File: tb/tb_twiddle_gen.sv
// tb/tb_twiddle_gen.sv - Directed self-checking bench for twiddle_gen at LOG2N=4
module tb_twiddle_gen;

  localparam int LOG2N = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  stage = 2'd0;
  logic        busy;
  logic        twiddle_valid;
  logic        twiddle_last;
  logic [15:0] twiddle_real;
  logic [16:0] twiddle_sum;
  logic [16:0] twiddle_diff;

  int n_checks = 0;
  int n_pass   = 0;

  // W_k for N=16 in Q1.15: real part cos, imaginary part -sin
  int exp_c [8] = '{32767, 30274, 23170, 12540, 0, -12540, -23170, -30274};
  int exp_s [8] = '{0, -12540, -23170, -30274, -32768, -30274, -23170, -12540};

  int obs_real [$];
  int obs_sum  [$];
  int obs_diff [$];
  int obs_last [$];
  int cap_first;
  int cap_lastv;
  int cap_fall;

  always #5 clk = ~clk;

  twiddle_gen #(.LOG2N(LOG2N), .TWIDDLE_FILE("twiddle_rom.hex")) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stage         (stage),
    .stall         (stall),
    .busy          (busy),
    .twiddle_valid (twiddle_valid),
    .twiddle_last  (twiddle_last),
    .twiddle_real  (twiddle_real),
    .twiddle_sum   (twiddle_sum),
    .twiddle_diff  (twiddle_diff)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic [1:0] s);
    start = 1'b1;
    stage = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Records every valid, unstalled output until busy drops; optional extra start at cycle inj_at
  task automatic capture(input int inj_at, input logic [1:0] inj_stage);
    obs_real.delete();
    obs_sum.delete();
    obs_diff.delete();
    obs_last.delete();
    cap_first = -1;
    cap_lastv = -1;
    cap_fall  = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (twiddle_valid && !stall) begin
        if (cap_first < 0) cap_first = c;
        cap_lastv = c;
        obs_real.push_back(int'($signed(twiddle_real)));
        obs_sum.push_back(int'($signed(twiddle_sum)));
        obs_diff.push_back(int'($signed(twiddle_diff)));
        obs_last.push_back(int'(twiddle_last));
      end
      start = (c == inj_at);
      if (c == inj_at) stage = inj_stage;
      if (!busy && cap_first >= 0) begin
        cap_fall = c;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b1;
    stage = 2'd0;
    repeat (3) @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++;
    if (twiddle_valid !== 1'b0 || twiddle_last !== 1'b0)
      $display("FAIL reset_valid_last: got %b%b expected 00", twiddle_valid, twiddle_last);
    else n_pass++;
    n_checks++;
    if (twiddle_real !== 16'h0 || twiddle_sum !== 17'h0 || twiddle_diff !== 17'h0)
      $display("FAIL reset_data: got %h %h %h expected 0 0 0", twiddle_real, twiddle_sum, twiddle_diff);
    else n_pass++;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || twiddle_valid !== 1'b0)
      $display("FAIL idle_after_release: got busy=%b valid=%b expected 0 0", busy, twiddle_valid);
    else n_pass++;
  endtask

  task automatic test_stage0();
    int k;
    int nl;
    pulse_start(2'd0);
    n_checks++;
    if (busy !== 1'b1 || twiddle_valid !== 1'b0)
      $display("FAIL s0_busy_rise: got busy=%b valid=%b expected 1 0", busy, twiddle_valid);
    else n_pass++;
    capture(0, 2'd0);
    n_checks++;
    if (cap_first != 3) $display("FAIL s0_latency: got %0d expected 3", cap_first); else n_pass++;
    n_checks++;
    if (obs_real.size() != 8) $display("FAIL s0_count: got %0d expected 8", obs_real.size()); else n_pass++;
    n_checks++;
    if (cap_lastv != 10) $display("FAIL s0_consecutive: got last at %0d expected 10", cap_lastv); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      k = i;
      n_checks++;
      if (i < obs_real.size() && obs_real[i] == exp_c[k] && obs_sum[i] == exp_c[k] + exp_s[k] &&
          obs_diff[i] == exp_s[k] - exp_c[k])
        n_pass++;
      else if (i < obs_real.size())
        $display("FAIL s0_out%0d: got %0d %0d %0d expected %0d %0d %0d", i, obs_real[i], obs_sum[i],
                 obs_diff[i], exp_c[k], exp_c[k] + exp_s[k], exp_s[k] - exp_c[k]);
      else
        $display("FAIL s0_out%0d: got none expected k=%0d", i, k);
    end
    nl = 0;
    foreach (obs_last[i]) nl += obs_last[i];
    n_checks++;
    if (nl == 1 && obs_last.size() == 8 && obs_last[7] == 1) n_pass++;
    else $display("FAIL s0_last: got %0d last flags expected 1 on output 8", nl);
    n_checks++;
    if (cap_fall != cap_lastv + 1)
      $display("FAIL s0_busy_fall: got cycle %0d expected %0d", cap_fall, cap_lastv + 1);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    int seq [8] = '{0, 2, 4, 6, 0, 2, 4, 6};
    int k;
    pulse_start(2'd1);
    capture(1, 2'd3);
    n_checks++;
    if (obs_real.size() != 8) $display("FAIL s1_count: got %0d expected 8", obs_real.size()); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      k = seq[i];
      n_checks++;
      if (i < obs_real.size() && obs_real[i] == exp_c[k] && obs_sum[i] == exp_c[k] + exp_s[k] &&
          obs_diff[i] == exp_s[k] - exp_c[k])
        n_pass++;
      else if (i < obs_real.size())
        $display("FAIL s1_out%0d: got real %0d expected %0d (k=%0d)", i, obs_real[i], exp_c[k], k);
      else
        $display("FAIL s1_out%0d: got none expected k=%0d", i, k);
    end
    n_checks++;
    if (obs_last.size() == 8 && obs_last[7] == 1 && obs_last[3] == 0) n_pass++;
    else $display("FAIL s1_last: got %0d outputs expected last only on 8", obs_last.size());
  endtask

  task automatic test_back_to_back();
    int k;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL b2b_idle: got busy=%b expected 0", busy); else n_pass++;
    pulse_start(2'd2);
    capture(0, 2'd0);
    n_checks++;
    if (cap_first != 3 || obs_real.size() != 8)
      $display("FAIL b2b_timing: got first=%0d count=%0d expected 3 8", cap_first, obs_real.size());
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      k = (i % 2) * 4;
      n_checks++;
      if (i < obs_real.size() && obs_real[i] == exp_c[k] && obs_diff[i] == exp_s[k] - exp_c[k]) n_pass++;
      else if (i < obs_real.size())
        $display("FAIL b2b_out%0d: got real %0d expected %0d (k=%0d)", i, obs_real[i], exp_c[k], k);
      else
        $display("FAIL b2b_out%0d: got none expected k=%0d", i, k);
    end
  endtask

  task automatic test_stage3();
    int bad;
    repeat (2) @(negedge clk);
    pulse_start(2'd3);
    capture(0, 2'd0);
    n_checks++;
    if (obs_real.size() != 8) $display("FAIL s3_count: got %0d expected 8", obs_real.size()); else n_pass++;
    bad = 0;
    foreach (obs_real[i])
      if (obs_real[i] != 32767 || obs_sum[i] != 32767 || obs_diff[i] != -32767) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL s3_all_k0: got %0d non-k0 outputs expected 0", bad); else n_pass++;
    n_checks++;
    if (obs_last.size() == 8 && obs_last[7] == 1 && obs_last[6] == 0) n_pass++;
    else $display("FAIL s3_last: got %0d outputs expected last only on 8", obs_last.size());
  endtask

  task automatic test_stall();
    int          frozen_bad;
    int          done;
    logic [15:0] snap_r;
    logic [16:0] snap_s;
    logic [16:0] snap_d;
    logic        snap_l;
    obs_real.delete();
    obs_last.delete();
    frozen_bad = 0;
    done       = 0;
    repeat (2) @(negedge clk);
    pulse_start(2'd0);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (twiddle_valid && !stall) begin
        obs_real.push_back(int'($signed(twiddle_real)));
        obs_last.push_back(int'(twiddle_last));
      end
      if (obs_real.size() == 3 && done == 0) begin
        snap_r = twiddle_real;
        snap_s = twiddle_sum;
        snap_d = twiddle_diff;
        snap_l = twiddle_last;
        stall  = 1'b1;
        for (int h = 0; h < 3; h++) begin
          @(negedge clk);
          if (twiddle_real !== snap_r || twiddle_sum !== snap_s || twiddle_diff !== snap_d ||
              twiddle_last !== snap_l || twiddle_valid !== 1'b1 || busy !== 1'b1)
            frozen_bad++;
        end
        stall = 1'b0;
        done  = 1;
      end
      if (!busy && obs_real.size() > 0) break;
    end
    n_checks++;
    if (frozen_bad != 0) $display("FAIL stall_frozen: got %0d changed cycles expected 0", frozen_bad); else n_pass++;
    n_checks++;
    if (obs_real.size() != 8) $display("FAIL stall_count: got %0d expected 8", obs_real.size()); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (i < obs_real.size() && obs_real[i] == exp_c[i]) n_pass++;
      else if (i < obs_real.size())
        $display("FAIL stall_out%0d: got real %0d expected %0d", i, obs_real[i], exp_c[i]);
      else
        $display("FAIL stall_out%0d: got none expected k=%0d", i, i);
    end
    n_checks++;
    if (obs_last.size() == 8 && obs_last[7] == 1 && obs_last[2] == 0) n_pass++;
    else $display("FAIL stall_last: got %0d outputs expected last only on 8", obs_last.size());
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    pulse_start(2'd0);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (twiddle_valid && !stall) n++;
      if (n == 4) break;
    end
    n_checks++;
    if (n != 4 || $signed(twiddle_real) != 16'sd12540)
      $display("FAIL mid_reach_out4: got n=%0d real=%0d expected 4 12540", n, $signed(twiddle_real));
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || twiddle_valid !== 1'b0 || twiddle_last !== 1'b0)
      $display("FAIL mid_reset_ctrl: got busy=%b valid=%b last=%b expected 0 0 0", busy, twiddle_valid, twiddle_last);
    else n_pass++;
    n_checks++;
    if (twiddle_real !== 16'h0 || twiddle_sum !== 17'h0 || twiddle_diff !== 17'h0)
      $display("FAIL mid_reset_data: got %h %h %h expected 0 0 0", twiddle_real, twiddle_sum, twiddle_diff);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start(2'd0);
    capture(0, 2'd0);
    n_checks++;
    if (obs_real.size() != 8) $display("FAIL mid_restart_count: got %0d expected 8", obs_real.size()); else n_pass++;
    n_checks++;
    if (obs_real.size() < 2 || obs_real[0] != 32767 || obs_real[1] != 30274)
      $display("FAIL mid_restart_j0: got %0d outputs expected k=0,1 first", obs_real.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stage0();
    test_start_ignored();
    test_back_to_back();
    test_stage3();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
